// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
//   Shared constants and helpers for the AES/Rijndael ShiftRows datapath.
//   - BYTE_W / NROWS / WORD_W : state geometry (4 rows of bytes per column)
//   - sr_off(nb, row)         : per-row rotation of ShiftRows for block width nb
//   - nb_legal(nb)            : true for the Rijndael widths handled here (4/6/8)
//   - byte_msb(nb, row, col)  : MSB bit index of byte s(row,col) in a packed state
//                               (column-major, s(0,0) at the MSB)
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int NROWS  = 4;
  localparam int WORD_W = NROWS * BYTE_W;

  // Rijndael row offsets: widths 4 and 6 rotate row r by r; width 8 uses {0,1,3,4}.
  function automatic int sr_off(input int nb, input int row);
    int off;
    off = 0;
    if (nb == 8) begin
      case (row)
        0:       off = 0;
        1:       off = 1;
        2:       off = 3;
        3:       off = 4;
        default: off = 0;
      endcase
    end else begin
      off = row;
    end
    return off;
  endfunction

  function automatic bit nb_legal(input int nb);
    return (nb == 4) || (nb == 6) || (nb == 8);
  endfunction

  function automatic int byte_msb(input int nb, input int row, input int col);
    return WORD_W * nb - 1 - BYTE_W * (NROWS * col + row);
  endfunction

endpackage

// File: rtl/aes_sr_perm.sv
// ---------------------------------------------------------------------------
// aes_sr_perm
//   Combinational ShiftRows / InvShiftRows byte permutation for a Rijndael
//   state of NB 32-bit columns. Pure wiring plus one 2:1 mux per bit, so it
//   can be dropped into key-schedule or debug paths as well.
// Parameters
//   NB    number of state columns; 4, 6 or 8
// Ports
//   inv   in   1        0 = ShiftRows, 1 = InvShiftRows
//   din   in   32*NB    input state, column-major, s(0,0) at the MSB
//   dout  out  32*NB    permuted state
// ---------------------------------------------------------------------------
module aes_sr_perm
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic                 inv,
  input  logic [WORD_W*NB-1:0] din,
  output logic [WORD_W*NB-1:0] dout
);

  localparam int W = WORD_W * NB;

  logic [W-1:0] fwd;
  logic [W-1:0] bwd;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("aes_sr_perm: NB must be 4, 6 or 8");
  end

  // Both directions are built as fixed wiring; the mode only selects between them,
  // so switching direction per beat costs no extra logic depth beyond the mux.
  for (genvar r = 0; r < NROWS; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int OFF  = sr_off(NB, r);
      localparam int FSRC = (c + OFF) % NB;
      localparam int BSRC = (c - OFF + NB) % NB;
      assign fwd[byte_msb(NB, r, c) -: BYTE_W] = din[byte_msb(NB, r, FSRC) -: BYTE_W];
      assign bwd[byte_msb(NB, r, c) -: BYTE_W] = din[byte_msb(NB, r, BSRC) -: BYTE_W];
    end
  end

  assign dout = inv ? bwd : fwd;

endmodule

// File: rtl/shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// shift_rows_pipe
//   Pipelined ShiftRows / InvShiftRows stage with valid/ready flow control.
//   The permutation is applied combinationally in front of the first register;
//   STAGES elastic register slices follow, each carrying valid, tag and data.
//   A beat accepted in cycle t leaves in cycle t+STAGES when not stalled.
// Parameters
//   NB      state columns (4, 6 or 8)
//   STAGES  register slices, 1..4
//   TAG_W   sideband tag width
// Ports
//   clk, rst               clock, asynchronous active-high reset
//   flush                  synchronous clear of every in-flight beat
//   in_valid / in_ready    input handshake
//   in_inv                 per-beat direction (1 = inverse)
//   in_tag / in_data       input sideband and state
//   out_valid / out_ready  output handshake
//   out_tag / out_data     output sideband and permuted state
// ---------------------------------------------------------------------------
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_inv,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic [WORD_W*NB-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [TAG_W-1:0]     out_tag,
  output logic [WORD_W*NB-1:0] out_data
);

  localparam int W = WORD_W * NB;

  if ((STAGES < 1) || (STAGES > 4)) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4");
  end

  logic [W-1:0] perm_data;

  aes_sr_perm #(
    .NB (NB)
  ) u_perm (
    .inv  (in_inv),
    .din  (in_data),
    .dout (perm_data)
  );

  // Each slice is a single-entry elastic register. Its ready (load) depends only
  // on its own valid and the slice downstream, so the ready chain runs back from
  // out_ready combinationally and a full pipe still moves one beat per cycle.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             up_valid;
    logic [W-1:0]     up_data;
    logic [TAG_W-1:0] up_tag;
    logic             down_ready;
    logic             advance;
    logic             load;
    logic             v_q;
    logic [W-1:0]     d_q;
    logic [TAG_W-1:0] t_q;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = perm_data;
      assign up_tag   = in_tag;
    end else begin : g_body
      assign up_valid = g_stage[k-1].advance;
      assign up_data  = g_stage[k-1].d_q;
      assign up_tag   = g_stage[k-1].t_q;
    end

    if (k == STAGES - 1) begin : g_tail
      assign down_ready = out_ready;
    end else begin : g_mid
      assign down_ready = g_stage[k+1].load;
    end

    assign advance = v_q & down_ready;
    assign load    = ~v_q | advance;

    // Slice register: flush drops every valid bit (payload left stale); payload
    // is only written when a beat is actually taken.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        d_q <= '0;
        t_q <= '0;
      end else if (flush) begin
        v_q <= 1'b0;
      end else if (load) begin
        v_q <= up_valid;
        if (up_valid) begin
          d_q <= up_data;
          t_q <= up_tag;
        end
      end
    end
  end

  assign in_ready  = g_stage[0].load;
  assign out_valid = g_stage[STAGES-1].v_q;
  assign out_data  = g_stage[STAGES-1].d_q;
  assign out_tag   = g_stage[STAGES-1].t_q;

endmodule

// File: tb/tb_shift_rows_pipe.sv
// ---------------------------------------------------------------------------
// tb_shift_rows_pipe
//   Self-checking bench for shift_rows_pipe. Four instances cover the
//   parameter sets needed: a (NB=4,S=1), b (NB=4,S=3), c (NB=8,S=2),
//   d (NB=4,S=2). Expected beats are queued when stimulus is accepted and
//   popped when the matching instance hands a beat out.
// ---------------------------------------------------------------------------
module tb_shift_rows_pipe;

  typedef struct {
    logic [255:0] data;
    logic [3:0]   tag;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int passed = 0;
  int total  = 0;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];
  exp_t qd[$];

  logic         a_flush, a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready;
  logic [3:0]   a_in_tag, a_out_tag;
  logic [127:0] a_in_data, a_out_data;
  logic         b_flush, b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready;
  logic [3:0]   b_in_tag, b_out_tag;
  logic [127:0] b_in_data, b_out_data;
  logic         c_flush, c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready;
  logic [3:0]   c_in_tag, c_out_tag;
  logic [255:0] c_in_data, c_out_data;
  logic         d_flush, d_in_valid, d_in_ready, d_in_inv, d_out_valid, d_out_ready;
  logic [3:0]   d_in_tag, d_out_tag;
  logic [127:0] d_in_data, d_out_data;

  shift_rows_pipe #(.NB(4), .STAGES(1), .TAG_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_inv(a_in_inv), .in_tag(a_in_tag), .in_data(a_in_data), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_tag(a_out_tag), .out_data(a_out_data));
  shift_rows_pipe #(.NB(4), .STAGES(3), .TAG_W(4)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_inv(b_in_inv), .in_tag(b_in_tag), .in_data(b_in_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_tag(b_out_tag), .out_data(b_out_data));
  shift_rows_pipe #(.NB(8), .STAGES(2), .TAG_W(4)) u_c (
    .clk(clk), .rst(rst), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_inv(c_in_inv), .in_tag(c_in_tag), .in_data(c_in_data), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_tag(c_out_tag), .out_data(c_out_data));
  shift_rows_pipe #(.NB(4), .STAGES(2), .TAG_W(4)) u_d (
    .clk(clk), .rst(rst), .flush(d_flush), .in_valid(d_in_valid), .in_ready(d_in_ready),
    .in_inv(d_in_inv), .in_tag(d_in_tag), .in_data(d_in_data), .out_valid(d_out_valid),
    .out_ready(d_out_ready), .out_tag(d_out_tag), .out_data(d_out_data));

  // Reference ShiftRows: state occupies the low 32*nb bits of the container.
  function automatic logic [255:0] sr_ref(input logic [255:0] din, input int nb, input bit inv);
    logic [255:0] res;
    int off;
    int src;
    res = '0;
    for (int r = 0; r < 4; r++) begin
      if (nb == 8) off = (r == 2) ? 3 : ((r == 3) ? 4 : r);
      else         off = r;
      for (int c = 0; c < nb; c++) begin
        src = inv ? ((c - off + nb) % nb) : ((c + off) % nb);
        res[32*nb-1-8*(4*c+r) -: 8] = din[32*nb-1-8*(4*src+r) -: 8];
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++;
    if ({a_out_valid, b_out_valid, c_out_valid, d_out_valid} !== 4'b0000)
      $display("FAIL reset_valid: got %b want 0000", {a_out_valid, b_out_valid, c_out_valid, d_out_valid});
    else passed++;
    total++;
    if ((a_out_data | b_out_data | d_out_data) !== 128'd0 || c_out_data !== 256'd0)
      $display("FAIL reset_data: got a=%h c=%h want 0", a_out_data, c_out_data);
    else passed++;
    total++;
    if ((a_out_tag | b_out_tag | c_out_tag | d_out_tag) !== 4'd0)
      $display("FAIL reset_tag: got a=%h b=%h want 0", a_out_tag, b_out_tag);
    else passed++;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    total++;
    if ({a_in_ready, b_in_ready, c_in_ready, d_in_ready} !== 4'b1111)
      $display("FAIL reset_in_ready: got %b want 1111", {a_in_ready, b_in_ready, c_in_ready, d_in_ready});
    else passed++;
  endtask

  task automatic test_fwd_nb4();
    exp_t e;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_tag = 4'h5;
    a_in_data = 128'hd42711aee0bf98f1b8b45de51e415230;
    @(negedge clk);
    total++;
    if (a_in_ready !== 1'b1) $display("FAIL t1_in_ready: got %b want 1", a_in_ready);
    else begin
      passed++;
      qa.push_back('{data: {128'd0, 128'hd4bf5d30e0b452aeb84111f11e2798e5}, tag: 4'h5});
    end
    @(posedge clk); #1 a_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (a_out_valid !== 1'b1 || qa.size() == 0) begin
      $display("FAIL t1_latency: got out_valid=%b want 1 one cycle after accept", a_out_valid);
    end else begin
      e = qa.pop_front();
      if (a_out_data !== e.data[127:0] || a_out_tag !== e.tag)
        $display("FAIL t1_data: got %h/%h want %h/%h", a_out_data, a_out_tag, e.data[127:0], e.tag);
      else passed++;
    end
  endtask

  task automatic test_inv_alt();
    logic [127:0] din  [5];
    logic [127:0] dexp [5];
    logic         invb [5];
    din  = '{128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h49ded28945db96f17f39871a7702533b,
             128'h49db873b453953897f02d2f177de961a, 128'h49ded28945db96f17f39871a7702533b,
             128'h49db873b453953897f02d2f177de961a};
    dexp = '{128'hd42711aee0bf98f1b8b45de51e415230, 128'h49db873b453953897f02d2f177de961a,
             128'h49ded28945db96f17f39871a7702533b, 128'h49db873b453953897f02d2f177de961a,
             128'h49ded28945db96f17f39871a7702533b};
    invb = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    a_out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          a_in_valid = 1'b1; a_in_inv = invb[i]; a_in_data = din[i]; a_in_tag = 4'(i + 1);
          @(negedge clk);
          total++;
          if (a_in_ready !== 1'b1) $display("FAIL t2_in_ready beat %0d: got %b want 1", i, a_in_ready);
          else begin
            passed++;
            qa.push_back('{data: {128'd0, dexp[i]}, tag: 4'(i + 1)});
          end
        end
        @(posedge clk); #1 a_in_valid = 1'b0;
      end
      begin
        int got = 0;
        int last = 0;
        exp_t e;
        for (int n = 0; n < 30 && got < 5; n++) begin
          @(negedge clk);
          if (a_out_valid) begin
            total++;
            if (qa.size() == 0) $display("FAIL t2_unexpected: got beat %h want none", a_out_data);
            else begin
              e = qa.pop_front();
              if (a_out_data !== e.data[127:0] || a_out_tag !== e.tag)
                $display("FAIL t2_data: got %h/%h want %h/%h", a_out_data, a_out_tag, e.data[127:0], e.tag);
              else passed++;
            end
            if (got > 0) begin
              total++;
              if (cyc !== last + 1) $display("FAIL t2_bubble: got cycle %0d want %0d", cyc, last + 1);
              else passed++;
            end
            last = cyc;
            got++;
          end
        end
        total++;
        if (got != 5) $display("FAIL t2_count: got %0d beats want 5", got);
        else passed++;
      end
    join
  endtask

  task automatic test_backpressure();
    logic [127:0] din  [4];
    logic         invb [4];
    logic [127:0] held_d;
    logic [3:0]   held_t;
    exp_t e;
    int got = 0;
    int last = 0;
    bit took = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din[i]  = rnd128();
      invb[i] = 1'($urandom_range(0, 1));
    end
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_inv = invb[i]; b_in_data = din[i]; b_in_tag = 4'(i + 1);
      @(negedge clk);
      total++;
      if (b_in_ready !== 1'b1) $display("FAIL t3_fill_ready beat %0d: got %b want 1", i, b_in_ready);
      else begin
        passed++;
        qb.push_back('{data: sr_ref({128'd0, din[i]}, 4, invb[i]), tag: 4'(i + 1)});
      end
    end
    @(posedge clk); #1;
    b_in_inv = invb[3]; b_in_data = din[3]; b_in_tag = 4'd4;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (b_in_ready !== 1'b0 || b_out_valid !== 1'b1)
        $display("FAIL t3_full: got in_ready=%b out_valid=%b want 0/1", b_in_ready, b_out_valid);
      else passed++;
      total++;
      if (n == 0) begin
        held_d = b_out_data;
        held_t = b_out_tag;
        if (held_t !== 4'd1) $display("FAIL t3_head_tag: got %h want 1", held_t);
        else passed++;
      end else begin
        if (b_out_data !== held_d || b_out_tag !== held_t)
          $display("FAIL t3_stall_stable: got %h/%h want %h/%h", b_out_data, b_out_tag, held_d, held_t);
        else passed++;
      end
      @(posedge clk); #1;
    end
    b_out_ready = 1'b1;
    for (int n = 0; n < 20 && got < 4; n++) begin
      @(negedge clk);
      if (b_in_valid && b_in_ready) begin
        qb.push_back('{data: sr_ref({128'd0, din[3]}, 4, invb[3]), tag: 4'd4});
        took = 1'b1;
      end
      if (b_out_valid && b_out_ready) begin
        total++;
        if (qb.size() == 0) $display("FAIL t3_unexpected: got beat %h want none", b_out_data);
        else begin
          e = qb.pop_front();
          if (b_out_data !== e.data[127:0] || b_out_tag !== 4'(got + 1))
            $display("FAIL t3_order: got %h/%h want %h/%h", b_out_data, b_out_tag, e.data[127:0], 4'(got + 1));
          else passed++;
        end
        if (got > 0) begin
          total++;
          if (cyc !== last + 1) $display("FAIL t3_rate: got cycle %0d want %0d", cyc, last + 1);
          else passed++;
        end
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (took) b_in_valid = 1'b0;
    end
    total++;
    if (got != 4) $display("FAIL t3_count: got %0d beats want 4", got);
    else passed++;
  endtask

  task automatic test_nb8();
    logic [255:0] pat;
    logic [255:0] r1;
    logic [255:0] rr;
    logic [255:0] din  [3];
    logic [255:0] dexp [3];
    logic         invb [3];
    for (int i = 0; i < 32; i++) pat[255-8*i -: 8] = 8'(i);
    r1 = sr_ref(pat, 8, 1'b0);
    rr = {rnd128(), rnd128()};
    din  = '{pat, r1, rr};
    dexp = '{r1, pat, sr_ref(rr, 8, 1'b1)};
    invb = '{1'b0, 1'b1, 1'b1};
    c_out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          c_in_valid = 1'b1; c_in_inv = invb[i]; c_in_data = din[i]; c_in_tag = 4'(i + 8);
          @(negedge clk);
          total++;
          if (c_in_ready !== 1'b1) $display("FAIL t4_in_ready beat %0d: got %b want 1", i, c_in_ready);
          else begin
            passed++;
            qc.push_back('{data: dexp[i], tag: 4'(i + 8)});
          end
        end
        @(posedge clk); #1 c_in_valid = 1'b0;
      end
      begin
        int got = 0;
        exp_t e;
        for (int n = 0; n < 30 && got < 3; n++) begin
          @(negedge clk);
          if (c_out_valid) begin
            total++;
            if (qc.size() == 0) $display("FAIL t4_unexpected: got beat %h want none", c_out_data);
            else begin
              e = qc.pop_front();
              if (c_out_data !== e.data || c_out_tag !== e.tag)
                $display("FAIL t4_data: got %h/%h want %h/%h", c_out_data, c_out_tag, e.data, e.tag);
              else passed++;
            end
            if (got == 0) begin
              // column 0 after forward shift: s(1,1)=05, s(2,3)=0e, s(3,4)=13
              total++;
              if (c_out_data[255:224] !== 32'h00050e13)
                $display("FAIL t4_col0: got %h want 00050e13", c_out_data[255:224]);
              else passed++;
            end
            got++;
          end
        end
        total++;
        if (got != 3) $display("FAIL t4_count: got %0d beats want 3", got);
        else passed++;
      end
    join
  endtask

  task automatic test_async_reset();
    exp_t e;
    d_out_ready = 1'b0;
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_in_inv = 1'b0; d_in_data = rnd128(); d_in_tag = 4'd1;
    @(posedge clk); #1;
    d_in_data = rnd128(); d_in_tag = 4'd2;
    @(posedge clk); #1 d_in_valid = 1'b0;
    #2;
    total++;
    if (d_out_valid !== 1'b1) $display("FAIL t5_in_flight: got out_valid=%b want 1", d_out_valid);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (d_out_valid !== 1'b0 || d_out_data !== 128'd0 || d_out_tag !== 4'd0)
      $display("FAIL t5_async_clear: got %b/%h/%h want 0/0/0", d_out_valid, d_out_data, d_out_tag);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    d_out_ready = 1'b1;
    qd.delete();
    @(negedge clk);
    total++;
    if (d_in_ready !== 1'b1) $display("FAIL t5_ready_after_rst: got %b want 1", d_in_ready);
    else passed++;
    @(posedge clk); #1;
    d_in_valid = 1'b1; d_in_inv = 1'b0; d_in_tag = 4'h9;
    d_in_data = 128'hac73cf7befc111df13b5d6b545235ab8;
    qd.push_back('{data: {128'd0, 128'hacc1d6b8efb55a7b1323cfdf457311b5}, tag: 4'h9});
    @(posedge clk); #1 d_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (d_out_valid !== 1'b0) $display("FAIL t5_early: got out_valid=%b data=%h want 0", d_out_valid, d_out_data);
    else passed++;
    @(negedge clk);
    total++;
    if (d_out_valid !== 1'b1 || qd.size() == 0) begin
      $display("FAIL t5_latency: got out_valid=%b want 1 two cycles after accept", d_out_valid);
    end else begin
      e = qd.pop_front();
      if (d_out_data !== e.data[127:0] || d_out_tag !== e.tag)
        $display("FAIL t5_data: got %h/%h want %h/%h", d_out_data, d_out_tag, e.data[127:0], e.tag);
      else passed++;
    end
    @(negedge clk);
    total++;
    if (d_out_valid !== 1'b0) $display("FAIL t5_dup: got out_valid=%b want 0", d_out_valid);
    else passed++;
  endtask

  task automatic test_flush();
    logic [127:0] r;
    exp_t e;
    int seen = 0;
    int at = -1;
    // beat presented together with flush on an empty, ready stage is dropped
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b1; a_in_inv = 1'b0; a_in_data = rnd128(); a_in_tag = 4'h3; a_flush = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0; a_flush = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL t6_flush_beat_dropped: got %0d beats want 0", seen);
    else passed++;
    // full pipe, flush with in_valid high
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = rnd128(); b_in_tag = 4'(i + 1);
    end
    @(posedge clk); #1;
    b_in_data = rnd128(); b_in_tag = 4'hf; b_flush = 1'b1;
    @(negedge clk);
    total++;
    if (b_out_valid !== 1'b1 || b_in_ready !== 1'b0)
      $display("FAIL t6_full_before: got out_valid=%b in_ready=%b want 1/0", b_out_valid, b_in_ready);
    else passed++;
    @(posedge clk); #1;
    b_flush = 1'b0; b_in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1)
      $display("FAIL t6_after_flush: got out_valid=%b in_ready=%b want 0/1", b_out_valid, b_in_ready);
    else passed++;
    b_out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (b_out_valid) seen++;
    end
    total++;
    if (seen != 0) $display("FAIL t6_no_output: got %0d beats want 0", seen);
    else passed++;
    r = rnd128();
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_inv = 1'b1; b_in_data = r; b_in_tag = 4'h7;
    qb.push_back('{data: sr_ref({128'd0, r}, 4, 1'b1), tag: 4'h7});
    @(posedge clk); #1 b_in_valid = 1'b0;
    for (int n = 0; n < 8 && at < 0; n++) begin
      @(negedge clk);
      if (b_out_valid) begin
        at = n;
        total++;
        if (qb.size() == 0) $display("FAIL t6_unexpected: got beat %h want none", b_out_data);
        else begin
          e = qb.pop_front();
          if (b_out_data !== e.data[127:0] || b_out_tag !== e.tag)
            $display("FAIL t6_data: got %h/%h want %h/%h", b_out_data, b_out_tag, e.data[127:0], e.tag);
          else passed++;
        end
      end
    end
    total++;
    if (at != 2) $display("FAIL t6_latency: got output at negedge %0d want 2", at);
    else passed++;
  endtask

  initial begin
    {a_flush, a_in_valid, a_in_inv, a_out_ready} = 4'b0000;
    {b_flush, b_in_valid, b_in_inv, b_out_ready} = 4'b0000;
    {c_flush, c_in_valid, c_in_inv, c_out_ready} = 4'b0000;
    {d_flush, d_in_valid, d_in_inv, d_out_ready} = 4'b0000;
    a_in_tag = 4'd0; b_in_tag = 4'd0; c_in_tag = 4'd0; d_in_tag = 4'd0;
    a_in_data = 128'd0; b_in_data = 128'd0; c_in_data = 256'd0; d_in_data = 128'd0;
    test_reset();
    test_fwd_nb4();
    test_inv_alt();
    test_backpressure();
    test_nb8();
    test_async_reset();
    test_flush();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog expired");
  end

endmodule
